// File: rtl/line_assembler_pkg.sv
// ---------------------------------------------------------------------------
// line_assembler_pkg
// Shared definitions for the input-side line assembler and its helpers.
//   RstEnable : level of rst that resets the block
//   NONDATA   : per-bit value used to pad unfilled line slots
//   state_t   : assembler states (ST_FILL accepts elements, ST_HOLD waits
//               for the output register to free up)
// ---------------------------------------------------------------------------
package line_assembler_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic NONDATA   = 1'b0;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/line_assembler_sat_clip.sv
// ---------------------------------------------------------------------------
// sat_clip
// Combinational unsigned saturation of one element to CLIP_MAX. When CLIP_EN
// is 0, the element passes through unchanged. Other input-side blocks reuse
// this module.
//   data    : incoming element
//   clipped : element limited to CLIP_MAX
// ---------------------------------------------------------------------------
module sat_clip
    import line_assembler_pkg::*;
#(
    parameter int          DATA_W   = 2,
    parameter int          CLIP_EN  = 1,
    parameter int unsigned CLIP_MAX = 2
) (
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] clipped
);

    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(CLIP_MAX);

    function automatic logic [DATA_W-1:0] saturate(input logic [DATA_W-1:0] d);
        if ((CLIP_EN != 0) && (d > MAX_V))
            return MAX_V;
        return d;
    endfunction

    assign clipped = saturate(data);

endmodule

// File: rtl/line_assembler.sv
// ---------------------------------------------------------------------------
// line_assembler
// Serial-to-parallel line assembler. Saturated elements are packed LINE_LEN
// at a time into a line. The line is then presented on a valid/ready port
// with backpressure. A fill register plus an output register give one
// element per cycle while the consumer keeps up. flush closes a partial
// line, and the unused slots are zero-padded.
//   clk, rst    : clock; asynchronous active-high reset
//   in_data     : element                in_valid/in_ready : element handshake
//   flush       : close the current partial line
//   out_line    : packed line, element 0 in the low bits
//   out_len     : real elements in out_line
//   out_partial : line was closed by flush before it was full
//   out_valid   : line available          out_ready : consumer takes the line
// ---------------------------------------------------------------------------
module line_assembler
    import line_assembler_pkg::*;
#(
    parameter int          DATA_W   = 2,
    parameter int          LINE_LEN = 4,
    parameter int          CLIP_EN  = 1,
    parameter int unsigned CLIP_MAX = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [LINE_LEN*DATA_W-1:0]      out_line,
    output logic [$clog2(LINE_LEN+1)-1:0]   out_len,
    output logic                            out_partial,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int LEN_W  = $clog2(LINE_LEN + 1);
    localparam int IDX_W  = $clog2(LINE_LEN);
    localparam int LINE_W = LINE_LEN * DATA_W;

    state_t                   state;
    state_t                   state_next;
    logic [LEN_W-1:0]         cnt;
    logic [DATA_W-1:0]        fill [LINE_LEN];
    logic [DATA_W-1:0]        clipped;
    logic                     accept;
    logic                     close;
    logic                     slot_free;
    logic                     load;
    logic [LEN_W-1:0]         load_len;
    logic [LINE_W-1:0]        line_next;

    sat_clip #(
        .DATA_W   (DATA_W),
        .CLIP_EN  (CLIP_EN),
        .CLIP_MAX (CLIP_MAX)
    ) u_sat_clip (
        .data    (in_data),
        .clipped (clipped)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable)
            state <= ST_FILL;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: if (close && !slot_free) state_next = ST_HOLD;
            ST_HOLD: if (slot_free)           state_next = ST_FILL;
            default: state_next = ST_FILL;
        endcase
    end

    // Outputs of the FSM depend on registered state only
    always_comb begin
        in_ready = (state == ST_FILL);
    end

    // Close/transfer decisions. In HOLD no element is accepted, so load_len
    // is simply the length of the held line.
    always_comb begin
        accept    = in_valid && in_ready;
        load_len  = cnt + LEN_W'(accept);
        close     = (state == ST_FILL) &&
                    ((accept && (cnt == LEN_W'(LINE_LEN - 1))) ||
                     (flush && (load_len != '0)));
        slot_free = !out_valid || out_ready;
        load      = slot_free && (close || (state == ST_HOLD));
    end

    // Line image with this cycle's element folded in. Slots past the real
    // length are padded, because the fill register keeps stale data.
    always_comb begin
        line_next = '0;
        for (int i = 0; i < LINE_LEN; i++) begin
            if (LEN_W'(i) < load_len) begin
                if (accept && (cnt == LEN_W'(i)))
                    line_next[i*DATA_W +: DATA_W] = clipped;
                else
                    line_next[i*DATA_W +: DATA_W] = fill[i];
            end else begin
                line_next[i*DATA_W +: DATA_W] = {DATA_W{NONDATA}};
            end
        end
    end

    // Fill register, element count and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            cnt         <= '0;
            for (int i = 0; i < LINE_LEN; i++)
                fill[i] <= '0;
            out_line    <= '0;
            out_len     <= '0;
            out_partial <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (accept)
                fill[cnt[IDX_W-1:0]] <= clipped;

            // A line closing into HOLD keeps its length in cnt
            if (load)
                cnt <= '0;
            else if (accept)
                cnt <= load_len;

            if (load) begin
                out_line    <= line_next;
                out_len     <= load_len;
                out_partial <= (load_len != LEN_W'(LINE_LEN));
                out_valid   <= 1'b1;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_assembler.sv
// ---------------------------------------------------------------------------
// tb_line_assembler
// Three instances of line_assembler:
//   dut_a : DATA_W=2, LINE_LEN=4, clipping on (CLIP_MAX=2)
//   dut_b : same geometry and inputs as dut_a, clipping off
//   dut_c : DATA_W=4, LINE_LEN=7, CLIP_MAX=11, random traffic with a
//           queue-based reference model
// ---------------------------------------------------------------------------
module tb_line_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [1:0]  a_in_data;
    logic        a_in_valid, a_flush, a_out_ready;
    logic        a_in_ready, b_in_ready;
    logic [7:0]  a_out_line, b_out_line;
    logic [2:0]  a_out_len, b_out_len;
    logic        a_out_partial, b_out_partial, a_out_valid, b_out_valid;

    logic [3:0]  c_in_data;
    logic        c_in_valid, c_flush, c_out_ready, c_in_ready;
    logic [27:0] c_out_line;
    logic [2:0]  c_out_len;
    logic        c_out_partial, c_out_valid;

    line_assembler #(.DATA_W(2), .LINE_LEN(4), .CLIP_EN(1), .CLIP_MAX(2)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .flush(a_flush), .out_line(a_out_line),
        .out_len(a_out_len), .out_partial(a_out_partial),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    line_assembler #(.DATA_W(2), .LINE_LEN(4), .CLIP_EN(0), .CLIP_MAX(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(b_in_ready), .flush(a_flush), .out_line(b_out_line),
        .out_len(b_out_len), .out_partial(b_out_partial),
        .out_valid(b_out_valid), .out_ready(a_out_ready)
    );

    line_assembler #(.DATA_W(4), .LINE_LEN(7), .CLIP_EN(1), .CLIP_MAX(11)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .flush(c_flush), .out_line(c_out_line),
        .out_len(c_out_len), .out_partial(c_out_partial),
        .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [1:0] d);
        a_in_valid = 1'b1;
        a_in_data  = d;
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic expect_a(input string tag, input logic [7:0] line, input int len, input logic part);
        check({tag, "_valid"},   a_out_valid,   1'b1);
        check({tag, "_line"},    a_out_line,    line);
        check({tag, "_len"},     a_out_len,     len);
        check({tag, "_partial"}, a_out_partial, part);
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_valid"},   a_out_valid,   1'b0);
        check({tag, "_line"},    a_out_line,    8'h00);
        check({tag, "_len"},     a_out_len,     0);
        check({tag, "_partial"}, a_out_partial, 1'b0);
    endtask

    typedef struct {
        logic [27:0] line;
        int          len;
        logic        partial;
    } line_t;

    line_t q[$];
    int    cur[$];
    int    n_in  = 0;
    int    n_out = 0;

    initial begin
        logic        acc, take;
        logic [27:0] l;
        line_t       item;

        rst = 1'b1;
        a_in_data = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        c_in_data = '0; c_in_valid = 1'b0; c_flush = 1'b0; c_out_ready = 1'b0;
        step();
        expect_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();
        check("reset_in_ready", a_in_ready, 1'b1);

        // Basic line, consumer always ready
        feed(2'd1); feed(2'd0); feed(2'd2);
        check("basic_not_yet", a_out_valid, 1'b0);
        feed(2'd1);
        expect_a("basic", 8'b01_10_00_01, 4, 1'b0);
        check("basic_b_line", b_out_line, 8'b01_10_00_01);
        step();
        check("basic_drop", a_out_valid, 1'b0);

        // Saturation on/off
        feed(2'd3); feed(2'd3); feed(2'd1); feed(2'd3);
        expect_a("clip", 8'b10_01_10_10, 4, 1'b0);
        check("noclip_line", b_out_line, 8'b11_01_11_11);
        check("noclip_len", b_out_len, 4);
        step();

        // Backpressure
        a_out_ready = 1'b0;
        feed(2'd1); feed(2'd2); feed(2'd0); feed(2'd1);
        expect_a("bp_first", 8'b01_00_10_01, 4, 1'b0);
        feed(2'd2); feed(2'd2); feed(2'd1);
        check("bp_stable_line", a_out_line, 8'b01_00_10_01);
        check("bp_ready_fill", a_in_ready, 1'b1);
        feed(2'd0);
        check("bp_hold_ready", a_in_ready, 1'b0);
        check("bp_hold_line", a_out_line, 8'b01_00_10_01);
        step();
        check("bp_hold_ready2", a_in_ready, 1'b0);
        check("bp_hold_valid", a_out_valid, 1'b1);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        expect_a("bp_second", 8'b00_01_10_10, 4, 1'b0);
        check("bp_ready_back", a_in_ready, 1'b1);
        a_out_ready = 1'b1;
        step();
        check("bp_drained", a_out_valid, 1'b0);

        // Flush
        feed(2'd2); feed(2'd1);
        a_flush = 1'b1; step(); a_flush = 1'b0;
        expect_a("flush2", 8'b00_00_01_10, 2, 1'b1);
        step();
        check("flush2_drop", a_out_valid, 1'b0);
        a_flush = 1'b1; step(); a_flush = 1'b0;
        check("flush_idle", a_out_valid, 1'b0);
        step();
        check("flush_idle2", a_out_valid, 1'b0);
        feed(2'd1); feed(2'd1); feed(2'd1);
        a_flush = 1'b1; feed(2'd2); a_flush = 1'b0;
        expect_a("flush_full", 8'b10_01_01_01, 4, 1'b0);
        step();
        feed(2'd1);
        a_flush = 1'b1; feed(2'd2); a_flush = 1'b0;
        expect_a("flush_with_elem", 8'b00_00_10_01, 2, 1'b1);
        step();

        // Reset mid-line
        feed(2'd1); feed(2'd2);
        #2 rst = 1'b1;
        #1 expect_reset_outputs("rst_midline");
        #3 rst = 1'b0;
        step();
        check("rst_midline_ready", a_in_ready, 1'b1);
        feed(2'd0); feed(2'd1); feed(2'd2);
        check("rst_midline_fresh_wait", a_out_valid, 1'b0);
        feed(2'd2);
        expect_a("rst_midline_fresh", 8'b10_10_01_00, 4, 1'b0);
        step();

        // Reset while holding
        a_out_ready = 1'b0;
        feed(2'd1); feed(2'd1); feed(2'd1); feed(2'd1);
        feed(2'd2); feed(2'd2); feed(2'd2); feed(2'd2);
        check("rst_hold_pre", a_in_ready, 1'b0);
        #2 rst = 1'b1;
        #1 expect_reset_outputs("rst_hold");
        #2 rst = 1'b0;
        #1 check("rst_hold_ready", a_in_ready, 1'b1);
        step();
        a_out_ready = 1'b1;
        feed(2'd2); feed(2'd1); feed(2'd0);
        check("rst_hold_fresh_wait", a_out_valid, 1'b0);
        feed(2'd1);
        expect_a("rst_hold_fresh", 8'b01_00_01_10, 4, 1'b0);
        step();

        // Random traffic on dut_c against a queue model
        for (int cyc = 0; cyc < 10040; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 10000) begin
                c_in_valid  = ($urandom_range(0, 9) < 7);
                c_in_data   = 4'($urandom);
                c_flush     = ($urandom_range(0, 7) == 0);
                c_out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                c_in_valid  = 1'b0;
                c_flush     = (cyc == 10000);
                c_out_ready = 1'b1;
            end
            @(negedge clk);
            check("rnd_in_ready", c_in_ready, (q.size() < 2));
            check("rnd_out_valid", c_out_valid, (q.size() > 0));
            if (q.size() > 0) begin
                check("rnd_line", c_out_line, q[0].line);
                check("rnd_len", c_out_len, q[0].len);
                check("rnd_partial", c_out_partial, q[0].partial);
            end
            acc  = c_in_valid && (q.size() < 2);
            take = c_out_ready && (q.size() > 0);
            if (take) begin
                n_out += q[0].len;
                void'(q.pop_front());
            end
            if (acc) begin
                cur.push_back((c_in_data > 4'd11) ? 11 : int'(c_in_data));
                n_in++;
            end
            if (cur.size() == 7 || (c_flush && cur.size() > 0)) begin
                l = '0;
                for (int i = 0; i < cur.size(); i++)
                    l = l | (28'(cur[i]) << (4 * i));
                item.line    = l;
                item.len     = cur.size();
                item.partial = (cur.size() != 7);
                q.push_back(item);
                cur.delete();
            end
        end
        check("rnd_drained", q.size() + cur.size(), 0);
        check("rnd_elem_count", n_out, n_in);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/line_assembler.md
# line_assembler

Parametrised serial-to-parallel line assembler for the input path. It accepts one element per handshake, saturates each element to a configurable maximum and packs `LINE_LEN` elements into one line word. Completed lines are presented on a valid/ready output port with backpressure. One fill register and one output register give full throughput while the consumer keeps up. A flush input emits a zero-padded partial line. The block sits between the element source and the line-consuming compute stage, replacing the fixed four-element buffer.

## Interface
Parameters:
- `DATA_W`, default 2: element width in bits.
- `LINE_LEN`, default 4: elements per line, at least 2.
- `CLIP_EN`, default 1: enable saturation of incoming elements.
- `CLIP_MAX`, default 2: saturation ceiling, unsigned, less than 2^DATA_W.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input DATA_W: element.
- `in_valid` input 1: element offered.
- `in_ready` output 1: element can be accepted.
- `flush` input 1: close the current partial line.
- `out_line` output LINE_LEN*DATA_W: packed line; element 0 in bits [DATA_W-1:0].
- `out_len` output $clog2(LINE_LEN+1): number of real elements in `out_line`.
- `out_partial` output 1: line was closed by flush.
- `out_valid` output 1: line available.
- `out_ready` input 1: consumer takes the line.

## Operation
- An element is accepted when `in_valid && in_ready`.
- Clip: if `CLIP_EN` and `in_data > CLIP_MAX`, store `CLIP_MAX`; otherwise store `in_data`.
- Fill index `idx` runs 0..LINE_LEN-1. Each accepted element is written to fill slot `idx`, and `idx` increments.
- The output slot is free when `!out_valid || out_ready`.
- States:
  - FILL: `in_ready` = 1.
  - HOLD: `in_ready` = 0. A complete line is waiting for the output slot.
- Line close in FILL happens on either of:
  - accepting the element at idx = LINE_LEN-1;
  - `flush` with (idx > 0 or an element accepted this cycle).
- When the line closes in FILL:
  - If the output slot is free: load `out_line`, `out_len`, `out_partial`; set `out_valid`; `idx` becomes 0; stay in FILL.
  - Otherwise: go to HOLD and keep the fill register and its length.
- In HOLD, when the output slot frees: transfer the held line, `idx` becomes 0, go to FILL.
- Flush padding: unfilled slots become 0 (NONDATA). `out_len` is the accepted count and `out_partial` is 1. A full line has `out_len` = LINE_LEN and `out_partial` = 0, even if `flush` is coincident.
- Flush and an element in the same cycle: the element is included first, then the line closes.
- Flush is ignored in these cases:
  - FILL with idx = 0 and no element accepted;
  - any cycle in HOLD (the line is already closed).
- `out_valid` clears when the consumer takes the line (`out_valid && out_ready`) and no new line loads in that cycle. A transfer in the same cycle keeps it high with the new contents.
- The fill register is not cleared between lines. Only the padding rule defines the contents of stale slots.

## Timing
- Reset, asynchronous:
  - state FILL, idx 0, fill register 0;
  - `out_line` 0, `out_len` 0, `out_partial` 0, `out_valid` 0;
  - `in_ready` 1 once `rst` deasserts.
- Latency: last element accepted at edge k gives `out_valid`=1 in the cycle after edge k.
- Throughput: one element per cycle sustained while `out_ready`=1. No bubble at the line boundary.
- `in_ready` is a function of registered state only. There is no combinational path from `out_ready` to `in_ready`.
- All outputs are stable while `out_valid && !out_ready`.
- Reset mid-line or in HOLD discards all data. There is no partial emission.

## Structure
- Shared defines file:
  - `RstEnable` (1'b1);
  - `NONDATA` (all zero);
  - state encodings `ST_FILL` and `ST_HOLD`.
- Sub-module `sat_clip`: combinational, parametrised by DATA_W, CLIP_EN and CLIP_MAX. It is reused by other input-side blocks.
- The top module holds the fill register array, idx/count, the state machine and the output register.

## Test plan
- DATA_W=2, LINE_LEN=4, out_ready=1:
  - Stimulus: feed 1,0,2,1 back-to-back.
  - Required: out_line=8'b01_10_00_01, out_len=4, out_partial=0, out_valid high one cycle after the 4th accept.
- Clip:
  - Stimulus: feed 3,3,1,3 with CLIP_MAX=2.
  - Required: elements 2,2,1,2. With CLIP_EN=0 the line must hold 3,3,1,3.
- Backpressure:
  - Stimulus: hold out_ready=0; feed 8 elements.
  - Required: first line held stable; second line fills; in_ready drops after the 8th accept (HOLD).
  - Then: out_ready=1 for one cycle; the second line appears next cycle and in_ready returns to 1.
- Flush:
  - Stimulus: feed 2,1 then assert flush.
  - Required: out_line=8'b00_00_01_10, out_len=2, out_partial=1.
  - Also check: flush at idx=0 gives no output; flush with the 4th element gives out_len=4, out_partial=0.
- Reset:
  - Stimulus: assert rst asynchronously (mid-cycle) after 2 elements, and again while in HOLD.
  - Required: all outputs 0 immediately; after release, a fresh 4-element line is assembled from idx 0.
- Random:
  - Stimulus: LINE_LEN=7, DATA_W=4, random in_valid/out_ready/flush for 10k cycles.
  - Required: scoreboard matches all lines; no element lost or duplicated.
